// File: rtl/instr_decode_stage.sv
// RV32I(+M) decode stage: combinational decode of the fetch word into a
// two-entry (main + skid) registered pipeline with flush and an illegal counter.
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    input  logic [XLEN-1:0]  in_pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       out_opcode_o,
    output logic [5:0]       out_instr_o,
    output logic [4:0]       out_rd_o,
    output logic [4:0]       out_rs1_o,
    output logic [4:0]       out_rs2_o,
    output logic [XLEN-1:0]  out_imm_o,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    generate
        if (XLEN != 32) begin : g_bad_xlen
            $error("instr_decode_stage: XLEN must be 32");
        end
    endgenerate

    typedef enum logic [3:0] {
        OP_NO_OP    = 4'd0,
        OP_COMP     = 4'd1,
        OP_COMP_IMM = 4'd2,
        OP_STORE    = 4'd3,
        OP_LOAD     = 4'd4,
        OP_BRANCH   = 4'd5,
        OP_JALR     = 4'd6,
        OP_JAL      = 4'd7,
        OP_AUIPC    = 4'd8,
        OP_LUI      = 4'd9
    } opcode_e;

    typedef enum logic [5:0] {
        I_NO_OP = 6'd0,  I_ADD,   I_SUB,    I_SLL,   I_SRL,   I_SRA,   I_AND,
        I_OR,    I_XOR,   I_SLT,   I_SLTU,   I_ADDI,  I_SLLI,  I_SRLI,  I_SRAI,
        I_ANDI,  I_ORI,   I_XORI,  I_SLTI,   I_SLTIU, I_LUI,   I_AUIPC, I_LB,
        I_LBU,   I_LH,    I_LHU,   I_LW,     I_SB,    I_SH,    I_SW,    I_FENCE,
        I_FENCEI, I_BEQ,  I_BNE,   I_BLT,    I_BLTU,  I_BGE,   I_BGEU,  I_JAL,
        I_JALR,  I_MUL,   I_MULH,  I_MULHSU, I_MULHU, I_DIV,   I_DIVU,  I_REM,
        I_REMU,  I_BAD_INSTR
    } instr_e;

    typedef enum logic [2:0] {
        F_NONE, F_R, F_I, F_S, F_B, F_U, F_J
    } format_e;

    typedef struct packed {
        logic [3:0]      op;
        logic [5:0]      ins;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = in_instr_i[6:0];
    assign funct3 = in_instr_i[14:12];
    assign funct7 = in_instr_i[31:25];

    logic [5:0] dec_ins;
    logic [3:0] dec_op;
    format_e    fmt;

    // Instruction classification; anything left at BAD_INSTR reverts to NO_OP class.
    always_comb begin
        dec_ins = I_BAD_INSTR;
        dec_op  = OP_NO_OP;
        fmt     = F_NONE;
        case (opcode)
            7'b0110011: begin
                dec_op = OP_COMP;
                fmt    = F_R;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: dec_ins = I_ADD;
                        3'b001: dec_ins = I_SLL;
                        3'b010: dec_ins = I_SLT;
                        3'b011: dec_ins = I_SLTU;
                        3'b100: dec_ins = I_XOR;
                        3'b101: dec_ins = I_SRL;
                        3'b110: dec_ins = I_OR;
                        default: dec_ins = I_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      dec_ins = I_SUB;
                    else if (funct3 == 3'b101) dec_ins = I_SRA;
                end else if (funct7 == 7'b0000001 && M_EXT != 0) begin
                    case (funct3)
                        3'b000: dec_ins = I_MUL;
                        3'b001: dec_ins = I_MULH;
                        3'b010: dec_ins = I_MULHSU;
                        3'b011: dec_ins = I_MULHU;
                        3'b100: dec_ins = I_DIV;
                        3'b101: dec_ins = I_DIVU;
                        3'b110: dec_ins = I_REM;
                        default: dec_ins = I_REMU;
                    endcase
                end
            end
            7'b0010011: begin
                dec_op = OP_COMP_IMM;
                fmt    = F_I;
                case (funct3)
                    3'b000: dec_ins = I_ADDI;
                    3'b010: dec_ins = I_SLTI;
                    3'b011: dec_ins = I_SLTIU;
                    3'b100: dec_ins = I_XORI;
                    3'b110: dec_ins = I_ORI;
                    3'b111: dec_ins = I_ANDI;
                    3'b001: if (funct7 == 7'b0000000) dec_ins = I_SLLI;
                    default: begin
                        if (funct7 == 7'b0000000)      dec_ins = I_SRLI;
                        else if (funct7 == 7'b0100000) dec_ins = I_SRAI;
                    end
                endcase
            end
            7'b0000011: begin
                dec_op = OP_LOAD;
                fmt    = F_I;
                case (funct3)
                    3'b000: dec_ins = I_LB;
                    3'b001: dec_ins = I_LH;
                    3'b010: dec_ins = I_LW;
                    3'b100: dec_ins = I_LBU;
                    3'b101: dec_ins = I_LHU;
                    default: dec_ins = I_BAD_INSTR;
                endcase
            end
            7'b0100011: begin
                dec_op = OP_STORE;
                fmt    = F_S;
                case (funct3)
                    3'b000: dec_ins = I_SB;
                    3'b001: dec_ins = I_SH;
                    3'b010: dec_ins = I_SW;
                    default: dec_ins = I_BAD_INSTR;
                endcase
            end
            7'b1100011: begin
                dec_op = OP_BRANCH;
                fmt    = F_B;
                case (funct3)
                    3'b000: dec_ins = I_BEQ;
                    3'b001: dec_ins = I_BNE;
                    3'b100: dec_ins = I_BLT;
                    3'b101: dec_ins = I_BGE;
                    3'b110: dec_ins = I_BLTU;
                    3'b111: dec_ins = I_BGEU;
                    default: dec_ins = I_BAD_INSTR;
                endcase
            end
            7'b1100111: begin
                dec_op = OP_JALR;
                fmt    = F_I;
                if (funct3 == 3'b000) dec_ins = I_JALR;
            end
            7'b1101111: begin
                dec_op  = OP_JAL;
                fmt     = F_J;
                dec_ins = I_JAL;
            end
            7'b0010111: begin
                dec_op  = OP_AUIPC;
                fmt     = F_U;
                dec_ins = I_AUIPC;
            end
            7'b0110111: begin
                dec_op  = OP_LUI;
                fmt     = F_U;
                dec_ins = I_LUI;
            end
            7'b0001111: begin
                if (funct3 == 3'b000)      dec_ins = I_FENCE;
                else if (funct3 == 3'b001) dec_ins = I_FENCEI;
            end
            default: dec_ins = I_BAD_INSTR;
        endcase
        if (dec_ins == I_BAD_INSTR) begin
            dec_op = OP_NO_OP;
            fmt    = F_NONE;
        end
    end

    entry_t dec;

    // Operand/immediate extraction driven by the instruction format.
    always_comb begin
        dec     = '0;
        dec.op  = dec_op;
        dec.ins = dec_ins;
        dec.pc  = in_pc_i;
        case (fmt)
            F_R: begin
                dec.rd  = in_instr_i[11:7];
                dec.rs1 = in_instr_i[19:15];
                dec.rs2 = in_instr_i[24:20];
            end
            F_I: begin
                dec.rd  = in_instr_i[11:7];
                dec.rs1 = in_instr_i[19:15];
                dec.imm = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
            end
            F_S: begin
                dec.rs1 = in_instr_i[19:15];
                dec.rs2 = in_instr_i[24:20];
                dec.imm = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
            end
            F_B: begin
                dec.rs1 = in_instr_i[19:15];
                dec.rs2 = in_instr_i[24:20];
                dec.imm = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                           in_instr_i[30:25], in_instr_i[11:8], 1'b0};
            end
            F_U: begin
                dec.rd  = in_instr_i[11:7];
                dec.imm = {in_instr_i[31:12], 12'b0};
            end
            F_J: begin
                dec.rd  = in_instr_i[11:7];
                dec.imm = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                           in_instr_i[20], in_instr_i[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    logic   m_valid;
    logic   s_valid;
    entry_t m_q;
    entry_t s_q;
    logic   accept;

    assign accept = in_valid_i && !s_valid && !flush_i;

    // Skid only fills while main is held, so s_valid always implies m_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else if (flush_i) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (s_valid) begin
            if (out_ready_i) begin
                m_q     <= s_q;
                s_valid <= 1'b0;
            end
        end else if (!m_valid || out_ready_i) begin
            m_valid <= accept;
            if (accept) m_q <= dec;
        end else if (accept) begin
            s_q     <= dec;
            s_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_o <= '0;
        end else if (accept && dec_ins == I_BAD_INSTR && illegal_cnt_o != {CNT_W{1'b1}}) begin
            illegal_cnt_o <= illegal_cnt_o + 1'b1;
        end
    end

    assign in_ready_o   = !s_valid;
    assign out_valid_o  = m_valid;
    assign out_opcode_o = m_q.op;
    assign out_instr_o  = m_q.ins;
    assign out_rd_o     = m_q.rd;
    assign out_rs1_o    = m_q.rs1;
    assign out_rs2_o    = m_q.rs2;
    assign out_imm_o    = m_q.imm;
    assign out_pc_o     = m_q.pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: a default instance plus an
// M_EXT=0 / CNT_W=2 instance for illegal decode and counter saturation.
module tb_instr_decode_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [5:0]  ins;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [3:0]  out_opcode;
    logic [5:0]  out_instr;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm, out_pc;
    logic [15:0] cnt;

    logic        in_valid2 = 1'b0, in_ready2;
    logic [31:0] in_instr2 = '0, in_pc2 = '0;
    logic        out_valid2, out_ready2 = 1'b1;
    logic [3:0]  out_opcode2;
    logic [5:0]  out_instr2;
    logic [4:0]  out_rd2, out_rs12, out_rs22;
    logic [31:0] out_imm2, out_pc2;
    logic [1:0]  cnt2;

    int   errors = 0;
    int   checks = 0;
    exp_t q_main[$];
    exp_t q_alt[$];
    exp_t got_main, exp_main, got_alt, exp_alt;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_pc_i(in_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_opcode_o(out_opcode), .out_instr_o(out_instr),
        .out_rd_o(out_rd), .out_rs1_o(out_rs1), .out_rs2_o(out_rs2),
        .out_imm_o(out_imm), .out_pc_o(out_pc), .illegal_cnt_o(cnt)
    );

    instr_decode_stage #(.XLEN(32), .M_EXT(0), .CNT_W(2)) dut_alt (
        .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
        .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_instr_i(in_instr2), .in_pc_i(in_pc2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .out_opcode_o(out_opcode2), .out_instr_o(out_instr2),
        .out_rd_o(out_rd2), .out_rs1_o(out_rs12), .out_rs2_o(out_rs22),
        .out_imm_o(out_imm2), .out_pc_o(out_pc2), .illegal_cnt_o(cnt2)
    );

    function automatic exp_t mk(input int op, input int ins, input int rd, input int rs1,
                                input int rs2, input logic [31:0] imm);
        exp_t e;
        e.op  = 4'(op);
        e.ins = 6'(ins);
        e.rd  = 5'(rd);
        e.rs1 = 5'(rs1);
        e.rs2 = 5'(rs2);
        e.imm = imm;
        e.pc  = '0;
        return e;
    endfunction

    // Monitors pop the expected entry whenever a transfer happens at the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            got_main = '{out_opcode, out_instr, out_rd, out_rs1, out_rs2, out_imm, out_pc};
            if (q_main.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_main unexpected output ins=%0d pc=%h, required none", out_instr, out_pc);
            end else begin
                exp_main = q_main.pop_front();
                if (got_main !== exp_main)
                    $display("[TB] FAIL sb_main got op=%0d ins=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h required op=%0d ins=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h",
                             got_main.op, got_main.ins, got_main.rd, got_main.rs1, got_main.rs2, got_main.imm, got_main.pc,
                             exp_main.op, exp_main.ins, exp_main.rd, exp_main.rs1, exp_main.rs2, exp_main.imm, exp_main.pc);
                if (got_main !== exp_main) errors++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2) begin
            checks++;
            got_alt = '{out_opcode2, out_instr2, out_rd2, out_rs12, out_rs22, out_imm2, out_pc2};
            if (q_alt.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_alt unexpected output ins=%0d pc=%h, required none", out_instr2, out_pc2);
            end else begin
                exp_alt = q_alt.pop_front();
                if (got_alt !== exp_alt)
                    $display("[TB] FAIL sb_alt got op=%0d ins=%0d rd=%0d imm=%h pc=%h required op=%0d ins=%0d rd=%0d imm=%h pc=%h",
                             got_alt.op, got_alt.ins, got_alt.rd, got_alt.imm, got_alt.pc,
                             exp_alt.op, exp_alt.ins, exp_alt.rd, exp_alt.imm, exp_alt.pc);
                if (got_alt !== exp_alt) errors++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s got %h required %h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the word is accepted.
    task automatic applyStimulus(input bit alt, input logic [31:0] instr, input logic [31:0] pc,
                                 input exp_t e);
        int n = 0;
        e.pc = pc;
        if (!alt) begin in_instr = instr; in_pc = pc; in_valid = 1'b1; end
        else      begin in_instr2 = instr; in_pc2 = pc; in_valid2 = 1'b1; end
        @(negedge clk);
        while (!(alt ? in_ready2 : in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(alt ? in_ready2 : in_ready)) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout pc=%h got in_ready=0 required 1", pc);
        end else if (!alt) q_main.push_back(e);
        else               q_alt.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values
        waitCycles(2);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_cnt", {16'b0, cnt}, 32'd0);
        checkOutput("rst_opcode_pc", {28'b0, out_opcode} | out_pc, 32'd0);
        rst_n = 1'b1;
        waitCycles(1);

        // Directed decode, streaming
        out_ready = 1'b1;
        applyStimulus(0, 32'h002081B3, 32'h1000, mk(1, 1, 3, 1, 2, 32'h0));
        applyStimulus(0, 32'hFFF00093, 32'h1004, mk(2, 11, 1, 0, 0, 32'hFFFFFFFF));
        applyStimulus(0, 32'hFE208EE3, 32'h1008, mk(5, 32, 0, 1, 2, 32'hFFFFFFFC));
        applyStimulus(0, 32'h027302B3, 32'h100C, mk(1, 40, 5, 6, 7, 32'h0));
        applyStimulus(0, 32'h123452B7, 32'h1010, mk(9, 20, 5, 0, 0, 32'h12345000));
        applyStimulus(0, 32'h0020A423, 32'h1014, mk(3, 29, 0, 1, 2, 32'h8));
        applyStimulus(0, 32'hFF812183, 32'h1018, mk(4, 26, 3, 2, 0, 32'hFFFFFFF8));
        applyStimulus(0, 32'h001000EF, 32'h101C, mk(7, 38, 1, 0, 0, 32'h800));
        applyStimulus(0, 32'h4030D093, 32'h1020, mk(2, 14, 1, 1, 0, 32'h403));
        applyStimulus(0, 32'hFFFFF117, 32'h1024, mk(8, 21, 2, 0, 0, 32'hFFFFF000));
        applyStimulus(0, 32'h40309093, 32'h1028, mk(0, 48, 0, 0, 0, 32'h0));
        applyStimulus(0, 32'h00000000, 32'h102C, mk(0, 48, 0, 0, 0, 32'h0));
        waitCycles(3);
        checkOutput("cnt_after_two_bad", {16'b0, cnt}, 32'd2);
        checkOutput("stream_drained", q_main.size(), 32'd0);

        // Backpressure: two fill M and S, third waits for release
        out_ready = 1'b0;
        applyStimulus(0, 32'h002081B3, 32'h100, mk(1, 1, 3, 1, 2, 32'h0));
        applyStimulus(0, 32'hFFF00093, 32'h104, mk(2, 11, 1, 0, 0, 32'hFFFFFFFF));
        @(negedge clk);
        checkOutput("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        fork
            applyStimulus(0, 32'h123452B7, 32'h108, mk(9, 20, 5, 0, 0, 32'h12345000));
            begin
                waitCycles(3);
                out_ready = 1'b1;
            end
        join
        waitCycles(3);
        checkOutput("bp_in_ready_high", {31'b0, in_ready}, 32'd1);
        checkOutput("bp_drained", q_main.size(), 32'd0);

        // Flush with M and S full and a bad word presented
        out_ready = 1'b0;
        applyStimulus(0, 32'h002081B3, 32'h200, mk(1, 1, 3, 1, 2, 32'h0));
        applyStimulus(0, 32'hFFF00093, 32'h204, mk(2, 11, 1, 0, 0, 32'hFFFFFFFF));
        in_instr = 32'h0;
        in_pc = 32'h208;
        in_valid = 1'b1;
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        in_valid = 1'b0;
        q_main.delete();
        checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);
        // Flush while the stage could have accepted the bad word
        in_instr = 32'h0;
        in_pc = 32'h20C;
        in_valid = 1'b1;
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_cnt_unchanged", {16'b0, cnt}, 32'd2);
        checkOutput("flush_empty_out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        applyStimulus(0, 32'h0020A423, 32'h210, mk(3, 29, 0, 1, 2, 32'h8));
        waitCycles(3);
        checkOutput("flush_drained", q_main.size(), 32'd0);

        // M_EXT=0 instance: MUL is illegal and counted
        applyStimulus(1, 32'h027302B3, 32'h300, mk(0, 48, 0, 0, 0, 32'h0));
        checkOutput("alt_mul_cnt", {30'b0, cnt2}, 32'd1);
        waitCycles(2);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        applyStimulus(0, 32'h123452B7, 32'h400, mk(9, 20, 5, 0, 0, 32'h12345000));
        applyStimulus(0, 32'h00000000, 32'h404, mk(0, 48, 0, 0, 0, 32'h0));
        #2;
        rst_n = 1'b0;
        #1;
        q_main.delete();
        checkOutput("arst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("arst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("arst_opcode_instr", {22'b0, out_instr, out_opcode}, 32'd0);
        checkOutput("arst_imm_pc_rd", out_imm | out_pc | {27'b0, out_rd}, 32'd0);
        checkOutput("arst_cnt", {16'b0, cnt}, 32'd0);
        checkOutput("arst_cnt_alt", {30'b0, cnt2}, 32'd0);
        waitCycles(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        waitCycles(1);

        // Saturating 2-bit counter: 1,2,3,3,3
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 32'h00000000, 32'h500 + 32'(4 * k), mk(0, 48, 0, 0, 0, 32'h0));
            checkOutput($sformatf("sat_cnt_%0d", k), {30'b0, cnt2}, (k < 3) ? 32'(k + 1) : 32'd3);
        end
        waitCycles(3);
        checkOutput("alt_drained", q_alt.size(), 32'd0);
        checkOutput("main_drained", q_main.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
